// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream program loader.
// Fills instruction memory and holds the CPU in reset while loading.
module imem_loader #(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   byte_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MEM_BYTES);

    state_t            state;
    state_t            state_d;
    logic [15:0]       len_q;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] addr;

    logic              acc;
    logic [15:0]       len_full;
    logic [7:0]        csum_sum;
    logic [ADDR_W:0]   cnt_nxt;

    // Handshake and the values an accepted byte would produce
    always_comb begin
        s_ready  = 1'b0;
        if (!start) begin
            unique case (state)
                LEN_LO, LEN_HI, DATA, CSUM: s_ready = 1'b1;
                default:                    s_ready = 1'b0;
            endcase
        end
        acc      = s_valid && s_ready;
        len_full = {s_data, len_q[7:0]};
        csum_sum = csum + s_data;
        cnt_nxt  = byte_cnt + 1'b1;
    end

    // Next-state decode; start overrides everything
    always_comb begin
        state_d = state;
        if (start) begin
            state_d = LEN_LO;
        end else if (acc) begin
            unique case (state)
                LEN_LO: state_d = LEN_HI;
                LEN_HI: begin
                    if (len_full > MAX_LEN)
                        state_d = ERR;
                    else if (len_full == 16'd0)
                        state_d = CSUM;
                    else
                        state_d = DATA;
                end
                DATA: begin
                    if (16'(cnt_nxt) == len_q)
                        state_d = CSUM;
                end
                CSUM: begin
                    if (csum_sum == 8'd0)
                        state_d = DONE;
                    else
                        state_d = ERR;
                end
                default: state_d = state;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Datapath: length capture, memory write port, checksum and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            csum      <= '0;
            addr      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            byte_cnt  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                len_q    <= '0;
                csum     <= '0;
                addr     <= '0;
                byte_cnt <= '0;
                done     <= 1'b0;
                err      <= 1'b0;
                cpu_hold <= 1'b1;
            end else if (acc) begin
                unique case (state)
                    LEN_LO: len_q[7:0] <= s_data;
                    LEN_HI: begin
                        len_q[15:8] <= s_data;
                        if (len_full > MAX_LEN)
                            err <= 1'b1;
                    end
                    DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= s_data;
                        addr      <= addr + 1'b1;
                        byte_cnt  <= cnt_nxt;
                        csum      <= csum_sum;
                    end
                    CSUM: begin
                        if (csum_sum == 8'd0) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
